alu_operand_arbiter: RTL and testbench

- Shares one 32-bit ALU between four requesters, ports 0..3.
- Round-robin arbitration.
- Drives the sel1/sel0 select pair shared by the operand/opcode 4:1 mux instances in front of the ALU.
- Sequences each transaction (issue, wait for ALU latency, capture result) and returns the result with a per-requester done pulse.

---
 rtl/alu_operand_arbiter_pkg.sv | 19 +
 rtl/alu_operand_arbiter_rr_priority_pick4.sv | 27 ++
 rtl/alu_operand_arbiter.sv | 110 +++++++++++
 tb/tb_alu_operand_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_arbiter_pkg.sv
// Shared constants and types for the four-port ALU operand arbiter.
// State encoding is fixed so the select/grant timing can be traced in waveforms by value.
package alu_operand_arbiter_pkg;

    localparam int NUM_REQ   = 4;
    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/alu_operand_arbiter_rr_priority_pick4.sv
// Round-robin pick among four requesters: first set bit strictly after the pointer, with wrap.
// The pointer's own requester has the lowest priority.
module rr_priority_pick4
    import alu_operand_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         pointer,
    output logic [1:0]         index,
    output logic               any
);

    logic [1:0] cand;

    always_comb begin
        index = '0;
        cand  = '0;
        any   = |req;
        // Walk from farthest to nearest so the nearest set bit after the pointer wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = pointer + 2'(k);
            if (req[cand]) begin
                index = cand;
            end
        end
    end

endmodule

// File: rtl/alu_operand_arbiter.sv
// Shares one ALU between four requesters: round-robin grant, operand mux select,
// issue strobe, latency wait, result capture and per-requester done pulse.
//
// state | meaning
// IDLE  | no transaction; arbitrate among pending requests
// ISSUE | operands selected, alu_start strobed, wait counter loaded
// WAIT  | ALU computing; result captured when counter reaches zero
// DONE  | done pulse to granted requester; pointer advanced; grant released
module alu_operand_arbiter
    import alu_operand_arbiter_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int ALU_LAT = 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic                sel1,
    output logic                sel0,
    output logic                alu_start,
    input  logic [WIDTH-1:0]    alu_result,
    output logic [WIDTH-1:0]    result,
    output logic [NUM_REQ-1:0]  done
);

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  gnt_q, gnt_nxt;
    logic [1:0]          idx_q, idx_nxt;
    logic [1:0]          ptr_q, ptr_nxt;
    logic [3:0]          cnt_q, cnt_nxt;
    logic [WIDTH-1:0]    result_q, result_nxt;

    logic [1:0]          pick_idx;
    logic                pick_any;

    rr_priority_pick4 u_pick (
        .req     (req),
        .pointer (ptr_q),
        .index   (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= 2'd3;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state    <= state_nxt;
            gnt_q    <= gnt_nxt;
            idx_q    <= idx_nxt;
            ptr_q    <= ptr_nxt;
            cnt_q    <= cnt_nxt;
            result_q <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt_q;
        idx_nxt    = idx_q;
        ptr_nxt    = ptr_q;
        cnt_nxt    = cnt_q;
        result_nxt = result_q;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt   = onehot4(pick_idx);
                    idx_nxt   = pick_idx;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = LAT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    result_nxt = alu_result;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ptr_nxt   = idx_q;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select comes from the registered index so it cannot move while the ALU computes.
    assign gnt       = gnt_q;
    assign sel1      = idx_q[1];
    assign sel0      = idx_q[0];
    assign alu_start = (state == ISSUE);
    assign done      = (state == DONE) ? gnt_q : '0;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Bench for alu_operand_arbiter: two instances (latency 1 and 4), a directed vector table,
// hand-written corner sequences, and a transaction-timeline reference model checked every cycle.
module tb_alu_operand_arbiter;
    import alu_operand_arbiter_pkg::*;

    localparam int W    = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [2];
    logic [3:0]   req [2];
    logic [W-1:0] alu_result [2];
    logic [3:0]   gnt [2];
    logic         sel1 [2];
    logic         sel0 [2];
    logic         alu_start [2];
    logic [W-1:0] result [2];
    logic [3:0]   done [2];

    alu_operand_arbiter #(.WIDTH(W), .ALU_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .gnt(gnt[0]), .sel1(sel1[0]), .sel0(sel0[0]),
        .alu_start(alu_start[0]), .alu_result(alu_result[0]), .result(result[0]), .done(done[0])
    );

    alu_operand_arbiter #(.WIDTH(W), .ALU_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .gnt(gnt[1]), .sel1(sel1[1]), .sel0(sel0[1]),
        .alu_start(alu_start[1]), .alu_result(alu_result[1]), .result(result[1]), .done(done[1])
    );

    int checks   = 0;
    int failures = 0;
    bit sb_on    = 1'b0;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        for (int j = 1; j <= 4; j++) begin
            int c;
            c = (int'(p) + j) % 4;
            if (r[c]) return 2'(c);
        end
        return 2'd0;
    endfunction

    // Reference: a transaction is a timeline of L+2 cycles after the grant edge
    // (offset 0 = issue, 1..L = wait, L+1 = done), followed by one idle cycle.
    logic [3:0]   m_gnt [2];
    logic [1:0]   m_sel [2];
    logic         m_start [2];
    logic [3:0]   m_done [2];
    logic [W-1:0] m_res [2];

    for (genvar g = 0; g < 2; g++) begin : g_model
        localparam int L = (g == 0) ? LAT0 : LAT1;
        logic         busy;
        int           k;
        logic [1:0]   win;
        logic [1:0]   ptr;
        logic [W-1:0] mres;

        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                busy <= 1'b0;
                k    <= 0;
                win  <= 2'd0;
                ptr  <= 2'd3;
                mres <= '0;
            end else if (!busy) begin
                if (req[g] != 4'd0) begin
                    win  <= rr_pick(req[g], ptr);
                    busy <= 1'b1;
                    k    <= 0;
                end
            end else if (k == L + 1) begin
                busy <= 1'b0;
                ptr  <= win;
            end else begin
                if (k == L) mres <= alu_result[g];
                k <= k + 1;
            end
        end

        assign m_gnt[g]   = busy ? (4'b0001 << win) : 4'b0000;
        assign m_sel[g]   = busy ? win : 2'd0;
        assign m_start[g] = busy && (k == 0);
        assign m_done[g]  = (busy && (k == L + 1)) ? (4'b0001 << win) : 4'b0000;
        assign m_res[g]   = mres;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_compare();
        for (int i = 0; i < 2; i++) begin
            logic [W+10:0] act, exp;
            act = {gnt[i], sel1[i], sel0[i], alu_start[i], done[i], result[i]};
            exp = {m_gnt[i], m_sel[i], m_start[i], m_done[i], m_res[i]};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_inst%0d {gnt,sel,start,done,result} actual=%h expected=%h at %0t",
                         i, act, exp, $time);
            end
        end
    endtask

    // Advance one cycle: model comparison on the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        if (sb_on) sb_compare();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]   req;
        logic [W-1:0] res;
        logic [3:0]   gnt;
        logic [1:0]   sel;
    } vec_t;

    vec_t tv [12];

    initial begin
        logic [3:0] order_q [$];
        logic [3:0] exp_order [4];
        int         seen;
        logic [3:0] dval;

        tv[0]  = '{4'b0001, 32'h0000_00AA, 4'b0001, 2'd0};
        tv[1]  = '{4'b1111, 32'h1111_0001, 4'b0010, 2'd1};
        tv[2]  = '{4'b1111, 32'h2222_0002, 4'b0100, 2'd2};
        tv[3]  = '{4'b1111, 32'h3333_0003, 4'b1000, 2'd3};
        tv[4]  = '{4'b1111, 32'h4444_0004, 4'b0001, 2'd0};
        tv[5]  = '{4'b0011, 32'h5555_0005, 4'b0010, 2'd1};
        tv[6]  = '{4'b0011, 32'h6666_0006, 4'b0001, 2'd0};
        tv[7]  = '{4'b0011, 32'h7777_0007, 4'b0010, 2'd1};
        tv[8]  = '{4'b1010, 32'h8888_0008, 4'b1000, 2'd3};
        tv[9]  = '{4'b0100, 32'h9999_0009, 4'b0100, 2'd2};
        tv[10] = '{4'b0101, 32'hAAAA_000A, 4'b0001, 2'd0};
        tv[11] = '{4'b1111, 32'hBBBB_000B, 4'b0010, 2'd1};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0;
            req[i] = 4'd0;
            alu_result[i] = '0;
        end
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_outputs_inst%0d", i),
                  W'({gnt[i], sel1[i], sel0[i], alu_start[i], done[i]}), '0);
            check($sformatf("reset_result_inst%0d", i), result[i], '0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        sb_on  = 1'b1;

        // Directed vector table on the latency-1 instance.
        for (int v = 0; v < 12; v++) begin
            req[0] = tv[v].req;
            alu_result[0] = tv[v].res;
            step();
            check($sformatf("tv%0d_issue_gnt", v), W'(gnt[0]), W'(tv[v].gnt));
            check($sformatf("tv%0d_issue_sel", v), W'({sel1[0], sel0[0]}), W'(tv[v].sel));
            check($sformatf("tv%0d_issue_start", v), W'(alu_start[0]), 1);
            step();
            check($sformatf("tv%0d_wait_start", v), W'(alu_start[0]), 0);
            step();
            check($sformatf("tv%0d_done", v), W'(done[0]), W'(tv[v].gnt));
            check($sformatf("tv%0d_result", v), result[0], tv[v].res);
            req[0] = 4'd0;
            step();
            check($sformatf("tv%0d_idle_done", v), W'(done[0]), 0);
            check($sformatf("tv%0d_idle_gnt", v), W'(gnt[0]), 0);
        end

        // All four requesting continuously from reset: rotation 0,1,2,3.
        rst[0] = 1'b1;
        #2;
        rst[0] = 1'b0;
        req[0] = 4'b1111;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int c = 0; c < 16; c++) begin
            step();
            if (alu_start[0]) order_q.push_back(gnt[0]);
        end
        req[0] = 4'd0;
        check("rotation_count", W'(order_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rotation_gnt%0d", i),
                  (i < order_q.size()) ? W'(order_q[i]) : W'(4'hF), W'(exp_order[i]));
        end
        step();

        // Latency 4: result changes only in the last wait cycle and must still be captured.
        req[1] = 4'b0100;
        alu_result[1] = 32'h1234_5678;
        step();
        check("lat4_issue_gnt", W'(gnt[1]), W'(4'b0100));
        check("lat4_issue_sel", W'({sel1[1], sel0[1]}), 2);
        check("lat4_issue_start", W'(alu_start[1]), 1);
        for (int w = 1; w <= 4; w++) begin
            step();
            check($sformatf("lat4_wait%0d_sel", w), W'({sel1[1], sel0[1]}), 2);
            check($sformatf("lat4_wait%0d_done", w), W'(done[1]), 0);
            if (w == 4) begin
                check("lat4_wait4_result_old", result[1], '0);
                alu_result[1] = 32'hDEAD_BEEF;
            end
        end
        step();
        check("lat4_done", W'(done[1]), W'(4'b0100));
        check("lat4_result", result[1], 32'hDEAD_BEEF);
        check("lat4_done_sel", W'({sel1[1], sel0[1]}), 2);
        req[1] = 4'd0;
        step();
        check("lat4_idle_gnt", W'(gnt[1]), 0);

        // Requester drops req mid-transaction; done still pulses on schedule.
        req[1] = 4'b1000;
        step();
        check("drop_issue_gnt", W'(gnt[1]), W'(4'b1000));
        step();
        req[1] = 4'd0;
        seen = -1;
        dval = 4'd0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (seen < 0 && done[1] != 4'd0) begin
                seen = n;
                dval = done[1];
            end
        end
        check("drop_done_cycle", W'(seen), 3);
        check("drop_done_value", W'(dval), W'(4'b1000));
        check("drop_no_regrant", W'(gnt[1]), 0);

        // Async reset mid-wait: outputs clear at once, pointer returns to 3.
        req[1] = 4'b1111;
        alu_result[1] = 32'hDEAD_BEEF;
        step();
        check("rst_seq_first_gnt", W'(gnt[1]), W'(4'b0001));
        for (int n = 0; n < 6; n++) step();
        step();
        check("rst_seq_second_gnt", W'(gnt[1]), W'(4'b0010));
        step();
        step();
        #2;
        rst[1] = 1'b1;
        #1;
        check("midrst_outputs", W'({gnt[1], sel1[1], sel0[1], alu_start[1], done[1]}), '0);
        check("midrst_result", result[1], '0);
        step();
        check("midrst_held_done", W'(done[1]), 0);
        rst[1] = 1'b0;
        step();
        check("postrst_gnt", W'(gnt[1]), W'(4'b0001));
        req[1] = 4'd0;
        for (int n = 0; n < 7; n++) step();

        // Randomized traffic against the timeline model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i] = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 3) == 0) req[i] = 4'($urandom_range(0, 15));
                alu_result[i] = $urandom;
            end
            step();
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        req[0] = 4'd0;
        req[1] = 4'd0;
        for (int n = 0; n < 10; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
